canny_nms_threshold_encoder: RTL and testbench

- Upstream producer of the 2-bit edge-class stream consumed by the Canny double-threshold/hysteresis stage.
- Takes a streamed gradient magnitude plus a quantised gradient direction and forms a 3x3 magnitude window from internal line buffers.
- Performs non-maximum suppression along the gradient direction, then encodes each surviving pixel against two thresholds: 2'b10 strong, 2'b01 weak, 2'b00 none.
- Output timing follows the codebase's vsync/href/clken video-stream interface.

---
 rtl/canny_nms_threshold_encoder.sv | 222 ++++++++++++++++++++++
 tb/tb_canny_nms_threshold_encoder.sv | 299 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/canny_nms_threshold_encoder.sv
// Canny non-maximum suppression plus double-threshold encoder on a vsync/href/clken pixel stream.
// Builds a 3x3 magnitude window from cascaded line buffers and emits a 2-bit edge class per pixel beat.

module canny_nms_threshold_encoder #(
    parameter int MAG_WIDTH  = 11,
    parameter int DATA_DEPTH = 640
) (
    input  logic                 clk,
    input  logic                 rst_s,
    input  logic                 pre_frame_vsync,
    input  logic                 pre_frame_href,
    input  logic                 pre_frame_clken,
    input  logic [MAG_WIDTH-1:0] grad_mag,
    input  logic [1:0]           grad_dir,
    input  logic [MAG_WIDTH-1:0] thr_high,
    input  logic [MAG_WIDTH-1:0] thr_low,
    output logic                 post_frame_vsync,
    output logic                 post_frame_href,
    output logic                 post_frame_clken,
    output logic [1:0]           max_g
);

    localparam int              AW       = (DATA_DEPTH > 1) ? $clog2(DATA_DEPTH) : 1;
    localparam int              RW       = 12;
    localparam logic [AW-1:0]   COL_LAST = AW'(DATA_DEPTH - 1);
    localparam logic [RW-1:0]   ROW_MAX  = {RW{1'b1}};

    // Stream protocol: a pixel is transferred on every cycle with pre_frame_clken high; there is
    // no stall path, so the three-stage pipeline advances every cycle and only storage waits on clken.

    logic                 r_vsync_d;
    logic                 r_href_d;
    logic                 w_vsync_rise;
    logic                 w_href_fall;
    logic [AW-1:0]        r_col;
    logic [RW-1:0]        r_row;
    logic [MAG_WIDTH-1:0] r_thr_high;
    logic [MAG_WIDTH-1:0] r_thr_low;

    assign w_vsync_rise = pre_frame_vsync & ~r_vsync_d;
    assign w_href_fall  = ~pre_frame_href & r_href_d;

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_vsync_d  <= 1'b0;
            r_href_d   <= 1'b0;
            r_col      <= '0;
            r_row      <= '0;
            r_thr_high <= '0;
            r_thr_low  <= '0;
        end else begin
            r_vsync_d <= pre_frame_vsync;
            r_href_d  <= pre_frame_href;

            if (!pre_frame_href) begin
                r_col <= '0;
            end else if (pre_frame_clken) begin
                r_col <= (r_col == COL_LAST) ? '0 : r_col + 1'b1;
            end

            if (w_vsync_rise) begin
                r_row <= '0;
            end else if (w_href_fall && (r_row != ROW_MAX)) begin
                r_row <= r_row + 1'b1;
            end

            // Thresholds are frozen per frame so a mid-frame change cannot split one image.
            if (w_vsync_rise) begin
                r_thr_high <= thr_high;
                r_thr_low  <= thr_low;
            end
        end
    end

    logic [MAG_WIDTH-1:0] r_lb_mag1 [DATA_DEPTH];
    logic [MAG_WIDTH-1:0] r_lb_mag2 [DATA_DEPTH];
    logic [1:0]           r_lb_dir  [DATA_DEPTH];
    logic [MAG_WIDTH-1:0] w_lb1_out;
    logic [MAG_WIDTH-1:0] w_lb2_out;
    logic [1:0]           w_dlb_out;

    assign w_lb1_out = r_lb_mag1[r_col];
    assign w_lb2_out = r_lb_mag2[r_col];
    assign w_dlb_out = r_lb_dir[r_col];

    // Read-before-write at the same column: each buffer returns the sample one line older.
    always_ff @(posedge clk) begin
        if (pre_frame_clken) begin
            r_lb_mag1[r_col] <= grad_mag;
            r_lb_mag2[r_col] <= w_lb1_out;
            r_lb_dir[r_col]  <= grad_dir;
        end
    end

    logic [MAG_WIDTH-1:0] r_p11, r_p12, r_p13;
    logic [MAG_WIDTH-1:0] r_p21, r_p22, r_p23;
    logic [MAG_WIDTH-1:0] r_p31, r_p32, r_p33;
    logic [1:0]           r_dir_d;
    logic [1:0]           r_dir_c;
    logic                 r_s1_clken;
    logic                 r_s1_border;
    logic [2:0]           r_vsync_pipe;
    logic [2:0]           r_href_pipe;
    logic [2:0]           r_clken_pipe;

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_p11        <= '0;
            r_p12        <= '0;
            r_p13        <= '0;
            r_p21        <= '0;
            r_p22        <= '0;
            r_p23        <= '0;
            r_p31        <= '0;
            r_p32        <= '0;
            r_p33        <= '0;
            r_dir_d      <= '0;
            r_dir_c      <= '0;
            r_s1_clken   <= 1'b0;
            r_s1_border  <= 1'b0;
            r_vsync_pipe <= '0;
            r_href_pipe  <= '0;
            r_clken_pipe <= '0;
        end else begin
            if (pre_frame_clken) begin
                r_p11   <= r_p12;
                r_p12   <= r_p13;
                r_p13   <= w_lb2_out;
                r_p21   <= r_p22;
                r_p22   <= r_p23;
                r_p23   <= w_lb1_out;
                r_p31   <= r_p32;
                r_p32   <= r_p33;
                r_p33   <= grad_mag;
                r_dir_d <= w_dlb_out;
                r_dir_c <= r_dir_d;
            end
            r_s1_clken   <= pre_frame_clken;
            r_s1_border  <= (r_row == '0) || (r_col == '0);
            r_vsync_pipe <= {r_vsync_pipe[1:0], pre_frame_vsync};
            r_href_pipe  <= {r_href_pipe[1:0], pre_frame_href};
            r_clken_pipe <= {r_clken_pipe[1:0], pre_frame_clken};
        end
    end

    logic [MAG_WIDTH-1:0] w_nb_a;
    logic [MAG_WIDTH-1:0] w_nb_b;

    always_comb begin
        w_nb_a = r_p21;
        w_nb_b = r_p23;
        case (r_dir_c)
            2'd1: begin
                w_nb_a = r_p13;
                w_nb_b = r_p31;
            end
            2'd2: begin
                w_nb_a = r_p12;
                w_nb_b = r_p32;
            end
            2'd3: begin
                w_nb_a = r_p11;
                w_nb_b = r_p33;
            end
            default: begin
                w_nb_a = r_p21;
                w_nb_b = r_p23;
            end
        endcase
    end

    logic r_s2_keep;
    logic r_s2_ge_high;
    logic r_s2_ge_low;
    logic r_s2_clken;
    logic r_s2_border;

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_s2_keep    <= 1'b0;
            r_s2_ge_high <= 1'b0;
            r_s2_ge_low  <= 1'b0;
            r_s2_clken   <= 1'b0;
            r_s2_border  <= 1'b0;
        end else begin
            r_s2_keep    <= (r_p22 >= w_nb_a) && (r_p22 >= w_nb_b);
            r_s2_ge_high <= (r_p22 >= r_thr_high);
            r_s2_ge_low  <= (r_p22 >= r_thr_low);
            r_s2_clken   <= r_s1_clken;
            r_s2_border  <= r_s1_border;
        end
    end

    logic [1:0] w_code;
    logic [1:0] r_max_g;

    // Strong test wins, so an inverted threshold pair never produces the weak code.
    always_comb begin
        w_code = 2'b00;
        if (!r_s2_border && r_s2_keep) begin
            if (r_s2_ge_high) begin
                w_code = 2'b10;
            end else if (r_s2_ge_low) begin
                w_code = 2'b01;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_s) begin
        if (!rst_s) begin
            r_max_g <= 2'b00;
        end else if (r_s2_clken) begin
            r_max_g <= w_code;
        end
    end

    assign post_frame_vsync = r_vsync_pipe[2];
    assign post_frame_href  = r_href_pipe[2];
    assign post_frame_clken = r_clken_pipe[2];
    assign max_g            = r_max_g;

endmodule

// File: tb/tb_canny_nms_threshold_encoder.sv
// Bench for canny_nms_threshold_encoder: directed and random frames against a stream-indexed
// reference model of the 3x3 neighbourhood, NMS and threshold encoding.
`timescale 1ns/1ps

module tb_canny_nms_threshold_encoder;

    localparam int MW   = 11;
    localparam int D    = 8;
    localparam int MAXR = 8;

    // ---------------- clock / reset / DUT ----------------
    logic          clk = 1'b0;
    logic          rst_s;
    logic          pre_frame_vsync;
    logic          pre_frame_href;
    logic          pre_frame_clken;
    logic [MW-1:0] grad_mag;
    logic [1:0]    grad_dir;
    logic [MW-1:0] thr_high;
    logic [MW-1:0] thr_low;
    logic          post_frame_vsync;
    logic          post_frame_href;
    logic          post_frame_clken;
    logic [1:0]    max_g;

    always #5 clk = ~clk;

    canny_nms_threshold_encoder #(
        .MAG_WIDTH (MW),
        .DATA_DEPTH(D)
    ) dut (
        .clk             (clk),
        .rst_s           (rst_s),
        .pre_frame_vsync (pre_frame_vsync),
        .pre_frame_href  (pre_frame_href),
        .pre_frame_clken (pre_frame_clken),
        .grad_mag        (grad_mag),
        .grad_dir        (grad_dir),
        .thr_high        (thr_high),
        .thr_low         (thr_low),
        .post_frame_vsync(post_frame_vsync),
        .post_frame_href (post_frame_href),
        .post_frame_clken(post_frame_clken),
        .max_g           (max_g)
    );

    // ---------------- checking ----------------
    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- reference model ----------------
    // Every accepted beat is appended to a flat history. With full-length lines, the pixel at
    // (row-a, col-b) relative to beat n sits at history index n - a*D - b.
    int         mag_hist[$];
    int         dir_hist[$];
    int         shadow_high;
    int         shadow_low;
    logic [2:0] exp_q[$];       // {known, code}
    int         f_mag[MAXR][D];
    int         f_dir[MAXR][D];

    function automatic int win(int n, int i, int j);
        return mag_hist[n - (3 - i) * D - (3 - j)];
    endfunction

    function automatic logic [2:0] expect_code(int n, int r, int c);
        int ctr;
        int a;
        int b;
        if (r == 0 || c == 0) return 3'b100;
        if (n - 2 * D - 2 < 0) return 3'b000;
        ctr = win(n, 2, 2);
        case (dir_hist[n - D - 1])
            0:       begin a = win(n, 2, 1); b = win(n, 2, 3); end
            1:       begin a = win(n, 1, 3); b = win(n, 3, 1); end
            2:       begin a = win(n, 1, 2); b = win(n, 3, 2); end
            default: begin a = win(n, 1, 1); b = win(n, 3, 3); end
        endcase
        if (ctr < a || ctr < b) return 3'b100;
        if (ctr >= shadow_high) return 3'b110;
        if (ctr >= shadow_low) return 3'b101;
        return 3'b100;
    endfunction

    // ---------------- monitor / scoreboard ----------------
    logic [2:0] sync_hist[3];
    int         rst_run = 0;
    logic [1:0] last_exp = 2'b00;
    bit         last_known = 1'b0;
    logic [2:0] mon_e;

    always @(negedge clk) begin
        if (!rst_s) begin
            rst_run    = 0;
            last_exp   = 2'b00;
            last_known = 1'b1;
        end else begin
            if (rst_run >= 3)
                check("post_syncs", 32'({post_frame_vsync, post_frame_href, post_frame_clken}),
                      32'(sync_hist[2]));
            if (post_frame_clken) begin
                if (exp_q.size() == 0) begin
                    check("extra_beat", 32'(exp_q.size()), 32'd1);
                end else begin
                    mon_e = exp_q.pop_front();
                    if (mon_e[2]) check("max_g", 32'(max_g), 32'(mon_e[1:0]));
                    last_exp   = mon_e[1:0];
                    last_known = mon_e[2];
                end
            end else if (last_known) begin
                check("max_g_hold", 32'(max_g), 32'(last_exp));
            end
            rst_run++;
        end
        sync_hist[2] = sync_hist[1];
        sync_hist[1] = sync_hist[0];
        sync_hist[0] = {pre_frame_vsync, pre_frame_href, pre_frame_clken};
    end

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int k);
        pre_frame_clken = 1'b0;
        repeat (k) begin
            grad_mag = MW'($urandom_range(0, 2047));
            grad_dir = 2'($urandom_range(0, 3));
            step();
        end
    endtask

    task automatic drive_beat(input int r, input int c);
        int n;
        pre_frame_clken = 1'b1;
        grad_mag = MW'(f_mag[r][c]);
        grad_dir = 2'(f_dir[r][c]);
        n = mag_hist.size();
        mag_hist.push_back(f_mag[r][c]);
        dir_hist.push_back(f_dir[r][c]);
        exp_q.push_back(expect_code(n, r, c));
        step();
    endtask

    task automatic start_frame();
        pre_frame_vsync = 1'b0;
        pre_frame_href  = 1'b0;
        idle_cycles(2);
        pre_frame_vsync = 1'b1;
        shadow_high = int'(thr_high);
        shadow_low  = int'(thr_low);
        idle_cycles(2);
    endtask

    // gap_mode: 0 none, 1 two idle beats before each pixel, 2 random 0..2 idle beats
    task automatic drive_frame(input int rows, input int gap_mode, input int chg_row,
                               input int chg_high);
        start_frame();
        for (int r = 0; r < rows; r++) begin
            pre_frame_href = 1'b1;
            idle_cycles(1);
            for (int c = 0; c < D; c++) begin
                if (gap_mode == 1) idle_cycles(2);
                else if (gap_mode == 2) idle_cycles($urandom_range(0, 2));
                drive_beat(r, c);
            end
            pre_frame_href = 1'b0;
            if (r == chg_row) thr_high = MW'(chg_high);
            idle_cycles(3);
        end
        idle_cycles(2);
        pre_frame_vsync = 1'b0;
    endtask

    // kind: 0 uniform 100, 1 ridge at column 3, 2 diagonal probe, 3 random wide, 4 random coarse
    task automatic fill(input int kind, input int dir_code);
        for (int r = 0; r < MAXR; r++) begin
            for (int c = 0; c < D; c++) begin
                f_dir[r][c] = dir_code;
                case (kind)
                    0: f_mag[r][c] = 100;
                    1: f_mag[r][c] = (c == 3) ? 200 : 50;
                    2: f_mag[r][c] = 10;
                    3: begin
                        f_mag[r][c] = $urandom_range(0, 255);
                        f_dir[r][c] = $urandom_range(0, 3);
                    end
                    default: begin
                        f_mag[r][c] = 50 * $urandom_range(0, 3);
                        f_dir[r][c] = $urandom_range(0, 3);
                    end
                endcase
            end
        end
        if (kind == 2) begin
            f_mag[0][2] = 95;
            f_mag[1][3] = 90;
        end
    endtask

    task automatic reset_mid_frame();
        fill(3, 0);
        start_frame();
        pre_frame_href = 1'b1;
        idle_cycles(1);
        for (int c = 0; c < 5; c++) drive_beat(0, c);
        pre_frame_clken = 1'b1;
        grad_mag = MW'(f_mag[0][5]);
        #2;
        rst_s = 1'b0;
        #1;
        check("midrst_vsync", 32'(post_frame_vsync), 32'd0);
        check("midrst_href", 32'(post_frame_href), 32'd0);
        check("midrst_clken", 32'(post_frame_clken), 32'd0);
        check("midrst_max_g", 32'(max_g), 32'd0);
        exp_q.delete();
        mag_hist.delete();
        dir_hist.delete();
        step();
        step();
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b0;
        step();
        rst_s = 1'b1;
        idle_cycles(4);
        pre_frame_vsync = 1'b0;
        idle_cycles(2);
    endtask

    // ---------------- main sequence ----------------
    initial begin
        rst_s           = 1'b1;
        pre_frame_vsync = 1'b0;
        pre_frame_href  = 1'b0;
        pre_frame_clken = 1'b0;
        grad_mag        = '0;
        grad_dir        = '0;
        thr_high        = '0;
        thr_low         = '0;
        #1;
        rst_s = 1'b0;
        #1;
        check("rst_vsync", 32'(post_frame_vsync), 32'd0);
        check("rst_href", 32'(post_frame_href), 32'd0);
        check("rst_clken", 32'(post_frame_clken), 32'd0);
        check("rst_max_g", 32'(max_g), 32'd0);
        repeat (3) step();
        rst_s = 1'b1;
        idle_cycles(3);

        fill(3, 0); thr_high = 11'd150; thr_low = 11'd60; drive_frame(4, 0, -1, 0);
        fill(0, 0); thr_high = 11'd80;  thr_low = 11'd40; drive_frame(4, 0, -1, 0);
        fill(1, 0); thr_high = 11'd150; thr_low = 11'd30; drive_frame(4, 0, -1, 0);
        fill(1, 2); drive_frame(4, 0, -1, 0);
        fill(2, 3); thr_high = 11'd100; thr_low = 11'd20; drive_frame(4, 0, -1, 0);
        fill(2, 1); drive_frame(4, 0, -1, 0);
        fill(0, 0); thr_high = 11'd150; thr_low = 11'd30; drive_frame(4, 0, 1, 60);
        drive_frame(4, 0, -1, 0);
        fill(1, 0); thr_high = 11'd150; thr_low = 11'd30; drive_frame(4, 1, -1, 0);

        reset_mid_frame();

        for (int k = 0; k < 8; k++) begin
            fill((k % 2 == 0) ? 3 : 4, 0);
            thr_high = MW'($urandom_range(0, 255));
            thr_low  = MW'($urandom_range(0, 255));
            drive_frame($urandom_range(3, 6), 2, $urandom_range(0, 3), $urandom_range(0, 255));
        end

        for (int i = 0; i < 40; i++) begin
            if (exp_q.size() == 0) break;
            step();
        end
        check("drain_empty", 32'(exp_q.size()), 32'd0);
        idle_cycles(2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        n_err++;
        $display("FAIL watchdog: got no end of stimulus, expected it within 50000 cycles");
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
